// File: rtl/gbe_read_depacketizer.sv
// Reassembles a byte stream from the TGE core into MSB-first DOUT_WIDTH words, with source filtering and frame length/error checks.
// One-cycle registered output latency per completed word or frame end; there is no backpressure, so dout_valid is a strobe.
module gbe_read_depacketizer #(
  parameter int DOUT_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_eof,
  input  logic                  rx_bad_frame,
  input  logic [31:0]           rx_source_ip,
  input  logic [15:0]           rx_source_port,
  input  logic [31:0]           config_rx_src_ip,
  input  logic [31:0]           config_rx_src_port,
  input  logic                  config_filter_en,
  input  logic [31:0]           pkt_len,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  output logic                  dout_err,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count
);

  localparam int B  = DOUT_WIDTH / 8;
  localparam int PW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t                state, state_nxt;
  logic [31:0]           byte_cnt, cnt_nxt;
  logic [PW-1:0]         wpos;
  logic [DOUT_WIDTH-1:0] acc, acc_nxt;
  logic                  accept, mismatch, word_done, frame_err;

  logic unused_ok;
  assign unused_ok = ^config_rx_src_port[31:16];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mismatch  = 1'b0;
    cnt_nxt   = byte_cnt;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          mismatch = config_filter_en &&
                     ((rx_source_ip != config_rx_src_ip) ||
                      (rx_source_port != config_rx_src_port[15:0]));
          if (mismatch) begin
            state_nxt = rx_eof ? IDLE : DROP;
          end else begin
            accept    = 1'b1;
            cnt_nxt   = 32'd1;
            state_nxt = rx_eof ? IDLE : RECV;
          end
        end
      end
      RECV: begin
        if (rx_valid) begin
          accept  = 1'b1;
          cnt_nxt = byte_cnt + 32'd1;
          if (rx_eof) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (rx_valid && rx_eof) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // acc is cleared after every emitted word, so a short final word is already zero-filled
    if (accept) begin
      for (int k = 0; k < B; k++) begin
        if (wpos == PW'(k)) acc_nxt[DOUT_WIDTH-1-8*k -: 8] = rx_data;
      end
    end

    word_done = accept && (rx_eof || (wpos == PW'(B - 1)));
    frame_err = rx_bad_frame || (cnt_nxt != pkt_len + 32'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      wpos       <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_err   <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= cnt_nxt;
      dout_valid <= word_done;
      dout_last  <= word_done && rx_eof;
      dout_err   <= word_done && rx_eof && frame_err;
      if (word_done) begin
        dout <= acc_nxt;
        acc  <= '0;
        wpos <= '0;
      end else if (accept) begin
        acc  <= acc_nxt;
        wpos <= wpos + PW'(1);
      end
      if (mismatch) begin
        drop_count <= drop_count + 32'd1;
      end else if (accept && rx_eof) begin
        if (frame_err) drop_count <= drop_count + 32'd1;
        else           pkt_count  <= pkt_count + 32'd1;
      end
    end
  end

endmodule
